temporal_encoder: RTL and testbench
===================================

TEMPORAL_ENCODER -- requirements
Module: temporal_encoder

Interface
REQ-001 The block SHALL have parameter GAMMA_CYCLE_WIDTH, default 16, number of aclk steps per gamma cycle (>=2).
REQ-002 The block SHALL have parameter NUM_INPUTS, default 16, number of temporal output lines.
REQ-003 The block SHALL have parameter VAL_WIDTH, default $clog2(GAMMA_CYCLE_WIDTH)+1, bit width of each binary value.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, as defined in REQ-005 and REQ-006.
REQ-005 The block SHALL have port aclk, input, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port grst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1, value vector offered.
REQ-008 The block SHALL have port in_ready, output, 1, shadow buffer can accept a vector.
REQ-009 The block SHALL have port in_values, input, NUM_INPUTS*VAL_WIDTH, packed values; line i at bits [i*VAL_WIDTH +: VAL_WIDTH].
REQ-010 The block SHALL have port edges, output, NUM_INPUTS, rising-edge temporal code, registered.
REQ-011 The block SHALL have port gamma_rst, output, 1, one-cycle inter-gamma reset pulse for downstream temporal blocks, registered.
REQ-012 The block SHALL have port step, output, $clog2(GAMMA_CYCLE_WIDTH), current gamma step, registered.
REQ-013 The block SHALL have port busy, output, 1, high in GRST or RUN state.

Function
REQ-014 The block SHALL hold a one-entry shadow buffer and an active value register.
REQ-015 The in_ready output SHALL equal NOT shadow_full, registered-state derived with no combinational path from in_valid.
REQ-016 When in_valid and in_ready are both high at an aclk edge, the block SHALL capture in_values into the shadow buffer and set shadow_full.
REQ-017 The block SHALL implement states IDLE, GRST and RUN.
REQ-018 In IDLE with shadow_full set, the next state SHALL be GRST; the shadow SHALL be copied to the active register and shadow_full cleared on that same edge.
REQ-019 GRST SHALL last exactly one cycle with gamma_rst=1, edges=0 and step=0; the next state SHALL be RUN with step=0.
REQ-020 In RUN at step t, edges[i] SHALL be 1 iff active value i <= t.
REQ-021 Any active value >= GAMMA_CYCLE_WIDTH SHALL mean "no spike": its line stays 0 for the whole gamma cycle.
REQ-022 The step counter SHALL increment by 1 per cycle in RUN, from 0 to GAMMA_CYCLE_WIDTH-1 with no wrap inside RUN.
REQ-023 At step GAMMA_CYCLE_WIDTH-1, the next state SHALL be GRST, with shadow transfer as in REQ-018, if shadow_full; otherwise it SHALL be IDLE.
REQ-024 Back-to-back gamma cycles SHALL therefore be spaced GAMMA_CYCLE_WIDTH+1 cycles apart.
REQ-025 Edges SHALL be monotonic within a gamma cycle: once a line is 1 it stays 1 until the next GRST or IDLE.
REQ-026 In IDLE, edges=0, gamma_rst=0 and step=0.
REQ-027 A handshake accepted in the same cycle that a transfer clears shadow_full SHALL be impossible by REQ-015, since in_ready=0 while full.
REQ-028 A vector accepted during RUN SHALL be held unaltered until that RUN ends.

Reset
REQ-029 While grst=1, the block SHALL force state=IDLE, shadow_full=0, active register=all-ones (no spike), edges=0, gamma_rst=0, step=0, busy=0 and in_ready=0.
REQ-030 After grst falls, in_ready SHALL be 1 on the first cycle.
REQ-031 A grst asserted mid-RUN or mid-GRST SHALL abort the gamma cycle and discard any shadow contents; no partial edges SHALL survive the reset edge.

Verification
REQ-032 Single vector, W=16: values line10=0, line1=1, line6=2, line8=3, line2=4, line4=5, line15=6, others=16 -> one gamma_rst pulse, then line10 high at step 0, line1 at step 1, ..., line15 at step 6; others 0 through step 15; IDLE after.
REQ-033 Back-to-back: two vectors handshaken, the second during RUN -> in_ready=0 until the first transfer; second GRST exactly 17 cycles after the first; no IDLE cycle between.
REQ-034 Boundary values: value=15 -> rises only at step 15; values 16 and 31 -> never rise; value 0 -> high from step 0; edges=0 during every GRST cycle.
REQ-035 Backpressure: in_valid held high with new data every cycle -> exactly one vector accepted per gamma cycle; accepted vectors emitted in order, none lost or duplicated.
REQ-036 Reset mid-operation: grst at step 7 with shadow full -> edges=0, busy=0, in_ready=0 next cycle; in_ready=1 the cycle after grst drops; the shadowed vector never emitted.

Source files
------------

// File: rtl/temporal_encoder.sv
// temporal_encoder
//   Turns a vector of small binary values into a rising-edge temporal code.
//   One vector is replayed over one gamma cycle of GAMMA_CYCLE_WIDTH steps.
//   Line i rises at the step equal to its value and then stays high.
//   A value of GAMMA_CYCLE_WIDTH or more never rises.
//   Each gamma cycle is preceded by a one-cycle gamma_rst pulse.
//   A one-entry shadow buffer allows the next vector to be accepted while
//   the current one is being replayed.
//
// Ports
//   aclk       : clock; all logic is on the rising edge
//   grst       : synchronous active-high reset
//   in_valid   : a value vector is offered on in_values
//   in_ready   : the shadow buffer can accept a vector
//   in_values  : packed values; line i at [i*VAL_WIDTH +: VAL_WIDTH]
//   edges      : registered temporal code, one bit per line
//   gamma_rst  : registered one-cycle pulse ahead of every gamma cycle
//   step       : registered current gamma step (0 outside RUN)
//   busy       : high while in GRST or RUN
module temporal_encoder #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int NUM_INPUTS        = 16,
   parameter int VAL_WIDTH         = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
   input  logic                                  aclk,
   input  logic                                  grst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [NUM_INPUTS*VAL_WIDTH-1:0]       in_values,
   output logic [NUM_INPUTS-1:0]                 edges,
   output logic                                  gamma_rst,
   output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0]  step,
   output logic                                  busy
);

   localparam int                STEP_W    = $clog2(GAMMA_CYCLE_WIDTH);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(GAMMA_CYCLE_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GRST = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [STEP_W-1:0]               cnt_q, cnt_d;
   logic                            shadow_full_q;
   logic [NUM_INPUTS*VAL_WIDTH-1:0] shadow_q;
   logic [NUM_INPUTS*VAL_WIDTH-1:0] active_q;
   logic                            accept;
   logic                            load;
   logic [NUM_INPUTS-1:0]           edges_d;
   logic                            gamma_rst_d;

   // A line fires once the step has reached its value. Values that cannot be
   // reached inside a gamma cycle (>= GAMMA_CYCLE_WIDTH) therefore never fire,
   // because the step never exceeds GAMMA_CYCLE_WIDTH-1.
   function automatic logic line_fires(input logic [VAL_WIDTH-1:0] val,
                                       input logic [STEP_W-1:0]    t);
      return val <= VAL_WIDTH'(t);
   endfunction

   // in_ready depends only on the shadow flag and reset, never on in_valid.
   // Gating with grst keeps the buffer closed for the whole reset interval
   // and reopens it on the very first cycle after reset drops.
   assign in_ready = ~shadow_full_q & ~grst;
   assign accept   = in_valid & in_ready;
   assign busy     = (state_q != IDLE);
   assign step     = cnt_q;

   // ---- state register ----
   always_ff @(posedge aclk) begin
      if (grst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- next-state logic ----
   // load marks the edge on which the shadow vector becomes the active one;
   // it always coincides with entering GRST.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (shadow_full_q) begin
               state_d = GRST;
               load    = 1'b1;
            end
         end
         GRST: begin
            state_d = RUN;
         end
         RUN: begin
            if (cnt_q == LAST_STEP) begin
               if (shadow_full_q) begin
                  state_d = GRST;
                  load    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + STEP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---- output logic (next values of the registered outputs) ----
   // The active register only changes when entering GRST, so while the next
   // state is RUN the current active_q is already the vector being replayed.
   always_comb begin
      gamma_rst_d = (state_d == GRST);
      edges_d     = '0;
      if (state_d == RUN) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            edges_d[i] = line_fires(active_q[i*VAL_WIDTH +: VAL_WIDTH], cnt_d);
         end
      end
   end

   // ---- control, active vector and registered outputs ----
   // The active register resets to all-ones so nothing can fire after reset.
   always_ff @(posedge aclk) begin
      if (grst) begin
         shadow_full_q <= 1'b0;
         active_q      <= '1;
         cnt_q         <= '0;
         edges         <= '0;
         gamma_rst     <= 1'b0;
      end else begin
         // accept and load are never both high: accept needs the shadow empty,
         // load needs it full.
         shadow_full_q <= accept | (shadow_full_q & ~load);
         if (load) begin
            active_q <= shadow_q;
         end
         cnt_q     <= cnt_d;
         edges     <= edges_d;
         gamma_rst <= gamma_rst_d;
      end
   end

   // ---- shadow data (qualified by shadow_full_q, so no reset needed) ----
   always_ff @(posedge aclk) begin
      if (accept) begin
         shadow_q <= in_values;
      end
   end

endmodule

// File: tb/tb_temporal_encoder.sv
module tb_temporal_encoder;

   localparam int W  = 16;
   localparam int NI = 16;
   localparam int VW = $clog2(W) + 1;
   localparam int SW = $clog2(W);

   typedef logic [NI*VW-1:0] vec_t;

   logic          aclk;
   logic          grst;
   logic          in_valid;
   logic          in_ready;
   vec_t          in_values;
   logic [NI-1:0] edges;
   logic          gamma_rst;
   logic [SW-1:0] step;
   logic          busy;

   temporal_encoder #(
      .GAMMA_CYCLE_WIDTH (W),
      .NUM_INPUTS        (NI),
      .VAL_WIDTH         (VW)
   ) dut (
      .aclk      (aclk),
      .grst      (grst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_values (in_values),
      .edges     (edges),
      .gamma_rst (gamma_rst),
      .step      (step),
      .busy      (busy)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference temporal code: line fires when its value is reachable and <= t.
   function automatic logic [NI-1:0] exp_edges(input vec_t v, input int t);
      logic [NI-1:0] r;
      logic [VW-1:0] f;
      int            val;
      r = '0;
      for (int i = 0; i < NI; i++) begin
         f    = v[i*VW +: VW];
         val  = int'(f);
         r[i] = (val < W) && (val <= t);
      end
      return r;
   endfunction

   function automatic vec_t set_line(input vec_t v, input int line, input int val);
      vec_t r;
      r = v;
      r[line*VW +: VW] = VW'(val);
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t r;
      r = '0;
      for (int i = 0; i < NI; i++) r[i*VW +: VW] = VW'($urandom_range(0, 31));
      return r;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   vec_t sb[$];
   vec_t cur;
   int   t_run     = 0;
   bit   running   = 1'b0;
   int   n_grst    = 0;
   int   n_push    = 0;
   int   n_pop     = 0;
   bit   bp_mode   = 1'b0;
   int   bp_seen   = 0;
   int   acc_since = 0;

   always @(negedge aclk) begin
      if (grst) begin
         // Reset discards the active cycle and any shadowed vector.
         sb.delete();
         running = 1'b0;
      end else begin
         if (gamma_rst) begin
            check("grst_edges", edges, 0);
            check("grst_step", step, 0);
            check("grst_busy", busy, 1);
            check("grst_not_mid_run", running, 0);
            n_grst++;
            if (bp_mode) begin
               if (bp_seen > 0) check("bp_one_accept_per_gamma", acc_since, 1);
               bp_seen++;
            end
            acc_since = 0;
            check("grst_has_vector", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               cur     = sb.pop_front();
               n_pop++;
               running = 1'b1;
               t_run   = 0;
            end
         end else if (running) begin
            check("run_step", step, t_run);
            check("run_edges", edges, exp_edges(cur, t_run));
            check("run_busy", busy, 1);
            t_run++;
            if (t_run == W) running = 1'b0;
         end else begin
            check("idle_edges", edges, 0);
            check("idle_step", step, 0);
            check("idle_busy", busy, 0);
         end
         if (in_valid && in_ready) begin
            sb.push_back(in_values);
            n_push++;
            acc_since++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input vec_t v);
      bit got;
      got = 1'b0;
      @(posedge aclk); #1;
      in_valid  = 1'b1;
      in_values = v;
      for (int k = 0; k < 100; k++) begin
         @(negedge aclk); #1;
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      check("send_accepted", got, 1);
      @(posedge aclk); #1;
      in_valid = 1'b0;
      @(negedge aclk); #1;
      check("rdy_low_after_accept", in_ready, 0);
   endtask

   task automatic wait_grst(output int c);
      bit seen;
      seen = 1'b0;
      c    = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge aclk); #1;
         if (gamma_rst) begin
            seen = 1'b1;
            c    = cyc;
            break;
         end
      end
      check("wait_grst_timeout", seen, 1);
   endtask

   task automatic wait_step(input int s);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge aclk); #1;
         if (running && !gamma_rst && step == SW'(s)) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_step_timeout", seen, 1);
   endtask

   task automatic wait_idle(input int max_cyc);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge aclk); #1;
         if (!busy && !running && !gamma_rst && sb.size() == 0) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_idle_timeout", seen, 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vec_t v, a, b;
      int   c1, c2, g0, p0;

      grst      = 1'b1;
      in_valid  = 1'b0;
      in_values = '0;

      // Reset state
      repeat (3) @(posedge aclk);
      @(negedge aclk); #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_edges", edges, 0);
      check("rst_gamma_rst", gamma_rst, 0);
      check("rst_step", step, 0);
      @(posedge aclk); #1;
      grst = 1'b0;
      @(negedge aclk); #1;
      check("rdy_first_cycle_after_rst", in_ready, 1);

      // Single vector: staircase on lines 10,1,6,8,2,4,15, others no spike
      v = '0;
      for (int i = 0; i < NI; i++) v = set_line(v, i, 16);
      v = set_line(v, 10, 0);
      v = set_line(v, 1, 1);
      v = set_line(v, 6, 2);
      v = set_line(v, 8, 3);
      v = set_line(v, 2, 4);
      v = set_line(v, 4, 5);
      v = set_line(v, 15, 6);
      g0 = n_grst;
      send(v);
      wait_idle(100);
      check("single_one_pulse", n_grst - g0, 1);

      // Boundary values 15, 16, 31, 0
      v = rand_vec();
      v = set_line(v, 0, 15);
      v = set_line(v, 1, 16);
      v = set_line(v, 2, 31);
      v = set_line(v, 3, 0);
      send(v);
      wait_idle(100);

      // Back-to-back: second vector accepted during RUN
      a = rand_vec();
      b = rand_vec();
      send(a);
      wait_grst(c1);
      wait_step(3);
      send(b);
      wait_grst(c2);
      check("b2b_gap", c2 - c1, W + 1);
      wait_idle(100);

      // Backpressure: valid held high, new data every cycle
      p0      = n_push;
      bp_seen = 0;
      bp_mode = 1'b1;
      for (int k = 0; k < 75; k++) begin
         @(posedge aclk); #1;
         in_valid  = 1'b1;
         in_values = rand_vec();
      end
      @(posedge aclk); #1;
      in_valid = 1'b0;
      bp_mode  = 1'b0;
      wait_idle(200);
      check("bp_accepts_flowed", (n_push - p0) >= 4, 1);
      check("bp_push_eq_pop", n_push, n_pop);

      // Reset mid-RUN with the shadow full
      a = rand_vec();
      b = rand_vec();
      for (int i = 0; i < 4; i++) a = set_line(a, i, i);
      send(a);
      wait_grst(c1);
      send(b);
      wait_step(7);
      grst = 1'b1;
      g0   = n_grst;
      @(negedge aclk); #1;
      check("midrst_edges", edges, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_step", step, 0);
      check("midrst_gamma_rst", gamma_rst, 0);
      @(posedge aclk); #1;
      grst = 1'b0;
      @(negedge aclk); #1;
      check("midrst_rdy_after", in_ready, 1);
      repeat (40) @(negedge aclk);
      #1;
      check("midrst_shadow_discarded", n_grst - g0, 0);

      check("sb_empty_end", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
